// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer for the five-stage pipeline: owns the zf/sf/cf flags,
// turns a taken MEM-stage jump into a PC load plus a timed flush of IF/ID/EX.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump,
  input  logic             mem_valid,
  input  logic [15:0]      mem_target,
  input  logic             stall_in,
  input  logic             ex_flag_we,
  input  logic             ex_zf,
  input  logic             ex_sf,
  input  logic             ex_cf,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             pc_load,
  output logic [15:0]      pc_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             busy,
  output logic [CNT_W-1:0] jump_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [3:0]       FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [2:0]       flags_reg, flags_next;
  logic [15:0]      target_reg, target_next;
  logic [CNT_W-1:0] jcnt_reg, jcnt_next;
  logic             trigger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      flags_reg  <= '0;
      target_reg <= '0;
      jcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      flags_reg  <= flags_next;
      target_reg <= target_next;
      jcnt_reg   <= jcnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    flags_next  = flags_reg;
    target_next = target_reg;
    jcnt_next   = jcnt_reg;
    trigger     = 1'b0;
    case (state_reg)
      IDLE: begin
        trigger = mem_valid & jump & ~stall_in;
        if (trigger) begin
          target_next = mem_target;
          if (jcnt_reg != '1)
            jcnt_next = jcnt_reg + CNT_ONE;
          state_next = REDIRECT;
        end else if (!stall_in && ex_flag_we) begin
          // EX flags commit only when no older jump is squashing EX
          flags_next = {ex_zf, ex_sf, ex_cf};
        end
      end
      REDIRECT: begin
        if (FLUSH_CYCLES == 1) begin
          state_next = IDLE;
        end else begin
          cnt_next   = FLUSH_RELOAD;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall_in) begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // outputs come from registers only, no input-to-output path
  assign pc_load    = (state_reg == REDIRECT);
  assign busy       = (state_reg != IDLE);
  assign flush_if   = busy;
  assign flush_id   = busy;
  assign flush_ex   = busy;
  assign pc_target  = target_reg;
  assign jump_count = jcnt_reg;
  assign zf         = flags_reg[2];
  assign sf         = flags_reg[1];
  assign cf         = flags_reg[0];

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized + directed bench for branch_redirect_ctrl with a scoreboard of
// expected redirects and a cycle-level reference model of flags and busy time.
module tb_branch_redirect_ctrl;

  localparam int FC   = 4;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jump, mem_valid, stall_in, ex_flag_we, ex_zf, ex_sf, ex_cf;
  logic [15:0]   mem_target;
  logic          zf, sf, cf, pc_load, flush_if, flush_id, flush_ex, busy;
  logic [15:0]   pc_target;
  logic [CW-1:0] jump_count;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .jump(jump), .mem_valid(mem_valid),
    .mem_target(mem_target), .stall_in(stall_in), .ex_flag_we(ex_flag_we),
    .ex_zf(ex_zf), .ex_sf(ex_sf), .ex_cf(ex_cf), .zf(zf), .sf(sf), .cf(cf),
    .pc_load(pc_load), .pc_target(pc_target), .flush_if(flush_if),
    .flush_id(flush_id), .flush_ex(flush_ex), .busy(busy), .jump_count(jump_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] target;
    int          count;
  } redirect_t;

  redirect_t sb[$];
  int checks = 0;
  int errors = 0;
  int flush_seen = 0;

  // reference model: remaining flush cycles, redirect flag, flags, counter
  int       m_left = 0;
  bit       m_pcload = 0;
  bit [2:0] m_flags = 0;
  int       m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_pcload = 0; m_flags = 0; m_cnt = 0;
  endtask

  // advance the model across one rising edge using the current inputs
  task automatic model_edge();
    if (m_left == 0) begin
      if (mem_valid && jump && !stall_in) begin
        if (m_cnt < MAXC) m_cnt++;
        m_left   = FC;
        m_pcload = 1;
        sb.push_back('{target: mem_target, count: m_cnt});
      end else if (!stall_in && ex_flag_we) begin
        m_flags = {ex_zf, ex_sf, ex_cf};
      end
    end else if (m_pcload) begin
      m_pcload = 0;
      m_left--;
    end else if (!stall_in) begin
      m_left--;
    end
  endtask

  task automatic check_state();
    chk("zf", 32'(zf), 32'(m_flags[2]));
    chk("sf", 32'(sf), 32'(m_flags[1]));
    chk("cf", 32'(cf), 32'(m_flags[0]));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("flush_if", 32'(flush_if), 32'(m_left > 0));
    chk("flush_id", 32'(flush_id), 32'(m_left > 0));
    chk("flush_ex", 32'(flush_ex), 32'(m_left > 0));
    chk("pc_load", 32'(pc_load), 32'(m_pcload));
    chk("jump_count", 32'(jump_count), 32'(m_cnt));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_state();
    if (flush_if) flush_seen++;
    $display("cyc t=%0t jump=%0b mv=%0b st=%0b we=%0b | pc_load=%0b tgt=%h busy=%0b flags=%0b%0b%0b cnt=%0d",
             $time, jump, mem_valid, stall_in, ex_flag_we, pc_load, pc_target, busy, zf, sf, cf, jump_count);
  endtask

  task automatic drive(input bit v, input bit j, input logic [15:0] t, input bit st,
                       input bit we, input bit z, input bit s, input bit c);
    mem_valid = v; jump = j; mem_target = t; stall_in = st;
    ex_flag_we = we; ex_zf = z; ex_sf = s; ex_cf = c;
  endtask

  // monitor: every pc_load pulse must match the oldest expected redirect
  always @(negedge clk) begin
    if (rst_n && pc_load) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pc_load: got pc_load=1 tgt=%h expected no redirect", pc_target);
      end else begin
        redirect_t e;
        e = sb.pop_front();
        chk("pc_target", 32'(pc_target), 32'(e.target));
        chk("redirect_count", 32'(jump_count), 32'(e.count));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_pc_target", 32'(pc_target), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // taken jump to 0x0040 with a flag write in the trigger cycle and in FLUSH
    repeat (3) step();
    drive(1, 1, 16'h0040, 0, 1, 1, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 1, 1, 0, 0);
    repeat (FC) step();
    chk("zf_squashed", 32'(zf), 32'h0);
    drive(1, 0, 16'h0099, 0, 1, 1, 0, 1);
    step();
    chk("zf_not_taken", 32'(zf), 32'h1);

    // stalled jump is ignored, then taken once the stall releases
    drive(1, 1, 16'h1234, 1, 1, 0, 1, 0);
    repeat (2) step();
    chk("no_redirect_stalled", 32'(busy), 32'h0);
    flush_seen = 0;
    drive(1, 1, 16'h1234, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0);
    repeat (3) step();
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && busy; i++) step();
    chk("flush_len_stalled", 32'(flush_seen), 32'(FC + 3));

    // jump held continuously: one redirect per sequence
    drive(1, 1, 16'hbeef, 0, 0, 0, 0, 0);
    repeat (3 * FC + 2) step();

    // reset pulse in the first FLUSH cycle
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    repeat (FC) step();
    drive(1, 1, 16'h5a5a, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 16'h0, 0, 1, 1, 1, 1);
    step();
    chk("in_flush_before_reset", 32'(busy & ~pc_load), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // normal redirects after reset, then counter saturation
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 16'(16'h0100 + k), 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
      repeat (FC) step();
    end
    chk("jump_count_saturated", 32'(jump_count), 32'(MAXC));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 9) < 3), 16'($urandom),
            ($urandom_range(0, 9) < 2), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      step();
    end

    drive(0, 0, 16'h0, 0, 0, 0, 0, 0);
    repeat (FC + 2) step();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow redirection for the 16-bit five-stage pipeline.
- Owns the architectural zf/sf/cf flag register that feeds the conditional-jump evaluator.
- Consumes that evaluator's jump decision for the MEM-stage instruction, and drives the PC load and the flushes of the younger stages.
- Blocks flag updates from squashed instructions and counts taken jumps for performance monitoring.

Parameters:
- FLUSH_CYCLES, 2: cycles the IF/ID/EX flushes stay asserted per redirect, counting the redirect cycle. Legal range 1..15.
- CNT_W, 16: width of the taken-jump counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- jump  in  1  jump decision for the current MEM-stage instruction, from the jump evaluator
- mem_valid  in  1  MEM stage holds a valid, non-squashed instruction
- mem_target  in  16  jump target address of the MEM-stage instruction
- stall_in  in  1  global pipeline stall (memory wait); freezes this block
- ex_flag_we  in  1  EX-stage instruction writes flags this cycle
- ex_zf, ex_sf, ex_cf  in  1 each  flag values produced by EX
- zf, sf, cf  out  1 each  registered architectural flags, to the jump evaluator
- pc_load  out  1  load pc_target into the PC this cycle
- pc_target  out  16  registered redirect address
- flush_if, flush_id, flush_ex  out  1 each  squash the IF/ID, ID/EX and EX/MEM pipeline registers
- busy  out  1  redirect or flush sequence in progress
- jump_count  out  CNT_W  number of taken jumps, saturating

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; zf=sf=cf=0; pc_target=0; flush counter=0; jump_count=0. All control outputs (pc_load, flush_*, busy) are 0. Deassertion is synchronous to clk as seen by the FSM.
- All outputs are registered or decoded from state only. No combinational path exists from any input to any output.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - Trigger = mem_valid & jump & !stall_in.
  - On the trigger: pc_target<=mem_target; jump_count increments, saturating at all-ones; next state REDIRECT.
  - If stall_in=1, jump is ignored that cycle. The stage holds, so jump is re-sampled once the stall releases.
- REDIRECT, exactly 1 cycle, not stretched by stall_in:
  - pc_load=1, flush_if=flush_id=flush_ex=1, busy=1.
  - If FLUSH_CYCLES==1, next state IDLE. Otherwise the counter loads FLUSH_CYCLES-1 and next state is FLUSH.
- FLUSH:
  - flush_*=1, busy=1, pc_load=0.
  - If stall_in=0, the counter decrements; on reaching 0 the next state is IDLE.
  - If stall_in=1, the counter and state hold.
  - jump, mem_valid and mem_target are ignored, because those instructions are being squashed.
- Latency: a trigger at edge N gives pc_load high for cycle N..N+1. The flushes span FLUSH_CYCLES cycles starting at that same edge, plus any stall cycles.
- Flag register:
  - In IDLE with stall_in=0 and ex_flag_we=1, {zf,sf,cf}<={ex_zf,ex_sf,ex_cf}.
  - The write is suppressed when stall_in=1.
  - The write is suppressed in REDIRECT and FLUSH.
  - The write is suppressed in the trigger cycle itself, because the EX instruction is younger than the taken jump.
  - A non-taken jump (jump=0) in the same cycle as ex_flag_we=1 performs the write normally.
- busy=1 exactly when state is not IDLE.
- Reset asserted mid-sequence aborts immediately: outputs clear, no residual pc_load or flush.
- jump_count never wraps; it sticks at 2^CNT_W-1.

Test Plan:
- Reset, then a taken jump: drive mem_valid=1, jump=1, mem_target=16'h0040 at edge 5. Expect pc_load=1 and pc_target=16'h0040 in cycle 5..6 only, flush_* high for 2 cycles, busy high for 2 cycles, jump_count=1.
- Flag squash: ex_flag_we=1 with ex_zf=1 on the trigger cycle and in the following FLUSH cycle. Expect zf stays 0. Repeat with jump=0: expect zf=1 after one edge.
- Stall interaction:
  - stall_in=1 together with jump=1 gives no redirect.
  - Release the stall: redirect occurs one edge later.
  - With FLUSH_CYCLES=4, stall_in=1 for 3 cycles during FLUSH: expect flush asserted 4+3=7 cycles total.
- Back-to-back: jump=1 held continuously during FLUSH. Expect exactly one pc_load and jump_count increments by 1 per sequence. A second trigger is accepted only after busy falls.
- Saturation with CNT_W=2: 5 taken jumps → jump_count=3.
- Reset mid-FLUSH: pulse rst_n low in the 1st FLUSH cycle. Expect busy, flush_*, pc_load, zf/sf/cf and jump_count all 0 asynchronously, and a normal redirect on the next trigger.
